riscv_mdu_iter: RTL and testbench

Iterative multiply/divide unit for the execute stage. It implements the full RV64M / RV32M operation set, including the W variants, using a shared shift-add datapath. Multiply retires a configurable number of bits per cycle; divide is restoring and retires one bit per cycle. A start/ready/valid/ack handshake with a kill input lets the hazard unit stall the pipeline while busy and flush in-flight work.

---
 rtl/riscv_mdu_iter.sv | 195 +++++++++++++++++++
 tb/tb_riscv_mdu_iter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/riscv_mdu_iter.sv
// riscv_mdu_iter: iterative RV64M/RV32M multiply/divide unit with a shared shift-add datapath
// Ports: i_riscv_mdu_clk/rst (clock, async active-low reset), i_riscv_mdu_start (request),
//        i_riscv_mdu_mulctrl/divctrl ({enable, op}), i_riscv_mdu_rs1data/rs2data (operands),
//        i_riscv_mdu_ack (result consumed), i_riscv_mdu_kill (flush),
//        o_riscv_mdu_ready/busy/valid (handshake status), o_riscv_mdu_result (result)
module riscv_mdu_iter #(
   parameter int XLEN    = 64,
   parameter int MUL_BPC = 2
) (
   input  logic            i_riscv_mdu_clk,
   input  logic            i_riscv_mdu_rst,
   input  logic            i_riscv_mdu_start,
   input  logic [3:0]      i_riscv_mdu_mulctrl,
   input  logic [3:0]      i_riscv_mdu_divctrl,
   input  logic [XLEN-1:0] i_riscv_mdu_rs1data,
   input  logic [XLEN-1:0] i_riscv_mdu_rs2data,
   input  logic            i_riscv_mdu_ack,
   input  logic            i_riscv_mdu_kill,
   output logic            o_riscv_mdu_ready,
   output logic            o_riscv_mdu_busy,
   output logic            o_riscv_mdu_valid,
   output logic [XLEN-1:0] o_riscv_mdu_result
);
   localparam int CW = $clog2(XLEN) + 1;
   typedef enum logic [2:0] {IDLE, MUL, DIV_PREP, DIV, DIV_FIX, DONE} state_t;
   state_t            st_q, st_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   // mul: {partial product, unconsumed multiplier}; div: {remainder, dividend/quotient}
   logic [2*XLEN-1:0] p_q, p_d;
   logic              w_q, w_d, hi_q, hi_d, sgn_q, sgn_d, rem_q, rem_d;
   logic              neg_q, neg_d, rneg_q, rneg_d, spec_q, spec_d, valid_q, valid_d;

   function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
      return {{(XLEN-31){v[31]}}, v[30:0]};
   endfunction

   assign o_riscv_mdu_ready  = st_q == IDLE || (st_q == DONE && i_riscv_mdu_ack);
   assign o_riscv_mdu_busy   = !(st_q == IDLE || st_q == DONE);
   assign o_riscv_mdu_valid  = valid_q;
   assign o_riscv_mdu_result = res_q;

   logic            mul_en, accept, w_i, msa, msb, dsx;
   logic [2:0]      op_i;
   logic [XLEN-1:0] ea, eb;
   always_comb begin
      mul_en = i_riscv_mdu_mulctrl[3];
      op_i   = mul_en ? i_riscv_mdu_mulctrl[2:0] : i_riscv_mdu_divctrl[2:0];
      w_i    = (XLEN == 64) && (mul_en ? op_i == 3'b100 : op_i[2]);
      // low-half products are sign-agnostic, so only MULH/MULHSU treat operands as signed
      msa    = mul_en && (op_i == 3'b001 || op_i == 3'b010);
      msb    = mul_en && op_i == 3'b001;
      dsx    = !mul_en && !op_i[0];
      ea     = w_i ? (dsx ? sx32(i_riscv_mdu_rs1data[31:0]) : XLEN'(i_riscv_mdu_rs1data[31:0])) : i_riscv_mdu_rs1data;
      eb     = w_i ? (dsx ? sx32(i_riscv_mdu_rs2data[31:0]) : XLEN'(i_riscv_mdu_rs2data[31:0])) : i_riscv_mdu_rs2data;
      accept = i_riscv_mdu_start && o_riscv_mdu_ready && !i_riscv_mdu_kill &&
               (i_riscv_mdu_mulctrl[3] || i_riscv_mdu_divctrl[3]);
   end

   logic [XLEN+MUL_BPC-1:0] sum;
   logic [2*XLEN-1:0]       mstep, prod, dstep;
   logic [XLEN:0]           rr, diff;
   logic [XLEN-1:0]         mres, aa, ab, dmin, dv;
   logic                    sa, sb, ovf, dz;
   always_comb begin
      sum = {{MUL_BPC{1'b0}}, p_q[2*XLEN-1:XLEN]};
      for (int i = 0; i < MUL_BPC; i++)
         sum = p_q[i] ? sum + ({{MUL_BPC{1'b0}}, a_q} << i) : sum;
      mstep = {sum, p_q[XLEN-1:MUL_BPC]};
      prod  = neg_q ? -p_q : p_q;
      // a 32-step W multiply leaves the product shifted up by XLEN-32
      mres  = w_q ? sx32(p_q[XLEN-1 -: 32]) : hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
      rr    = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
      diff  = rr - {1'b0, b_q};
      dstep = diff[XLEN] ? {p_q[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
      sa    = sgn_q && a_q[XLEN-1];
      sb    = sgn_q && b_q[XLEN-1];
      aa    = sa ? -a_q : a_q;
      ab    = sb ? -b_q : b_q;
      dmin  = w_q ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
      dz    = b_q == '0;
      ovf   = sgn_q && a_q == dmin && &b_q;
      // special-case results are already final and bypass the sign fix
      dv    = rem_q ? (rneg_q && !spec_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN])
                    : (neg_q && !spec_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0]);
   end

   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      res_d   = res_q;
      w_d     = w_q;
      hi_d    = hi_q;
      sgn_d   = sgn_q;
      rem_d   = rem_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      spec_d  = spec_q;
      valid_d = valid_q;
      if (i_riscv_mdu_kill) begin
         st_d    = IDLE;
         valid_d = 1'b0;
         res_d   = '0;
      end else if (accept) begin
         st_d    = mul_en ? MUL : DIV_PREP;
         valid_d = 1'b0;
         w_d     = w_i;
         hi_d    = mul_en && !op_i[2] && op_i[1:0] != 2'b00;
         sgn_d   = dsx;
         rem_d   = op_i[1];
         spec_d  = 1'b0;
         neg_d   = (msa && ea[XLEN-1]) ^ (msb && eb[XLEN-1]);
         a_d     = msa && ea[XLEN-1] ? -ea : ea;
         b_d     = eb;
         p_d     = {{XLEN{1'b0}}, msb && eb[XLEN-1] ? -eb : eb};
         cnt_d   = mul_en ? CW'((w_i ? 32 : XLEN) / MUL_BPC) : '0;
      end else begin
         case (st_q)
            MUL: begin
               if (cnt_q == '0) begin
                  st_d    = DONE;
                  res_d   = mres;
                  valid_d = 1'b1;
               end else begin
                  p_d   = mstep;
                  cnt_d = cnt_q - CW'(1);
               end
            end
            DIV_PREP: begin
               st_d   = dz || ovf ? DIV_FIX : DIV;
               spec_d = dz || ovf;
               neg_d  = sa ^ sb;
               rneg_d = sa;
               b_d    = ab;
               cnt_d  = CW'(w_q ? 32 : XLEN);
               // W dividends are left-aligned so the 32 steps consume their bits first
               p_d    = dz ? {a_q, {XLEN{1'b1}}} : ovf ? {{XLEN{1'b0}}, a_q}
                           : {{XLEN{1'b0}}, aa << (w_q ? XLEN - 32 : 0)};
            end
            DIV: begin
               p_d   = dstep;
               cnt_d = cnt_q - CW'(1);
               st_d  = cnt_q == CW'(1) ? DIV_FIX : DIV;
            end
            DIV_FIX: begin
               st_d    = DONE;
               res_d   = w_q ? sx32(dv[31:0]) : dv;
               valid_d = 1'b1;
            end
            DONE: begin
               st_d    = i_riscv_mdu_ack ? IDLE : DONE;
               valid_d = !i_riscv_mdu_ack;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_riscv_mdu_clk or negedge i_riscv_mdu_rst) begin
      if (!i_riscv_mdu_rst) begin
         st_q    <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         res_q   <= '0;
         w_q     <= 1'b0;
         hi_q    <= 1'b0;
         sgn_q   <= 1'b0;
         rem_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         spec_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         res_q   <= res_d;
         w_q     <= w_d;
         hi_q    <= hi_d;
         sgn_q   <= sgn_d;
         rem_q   <= rem_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         spec_q  <= spec_d;
         valid_q <= valid_d;
      end
   end
endmodule

// File: tb/tb_riscv_mdu_iter.sv
// tb_riscv_mdu_iter: directed self-checking bench for riscv_mdu_iter (XLEN=64, MUL_BPC=2)
module tb_riscv_mdu_iter;
   logic        clk = 0, rst_n = 1, start = 0, ack = 0, kill = 0;
   logic [3:0]  mc = 0, dc = 0;
   logic [63:0] rs1 = 0, rs2 = 0;
   logic        ready, busy, valid;
   logic [63:0] result;
   int          total = 0, fails = 0, lat, n;

   riscv_mdu_iter #(.XLEN(64), .MUL_BPC(2)) dut (
      .i_riscv_mdu_clk(clk),
      .i_riscv_mdu_rst(rst_n),
      .i_riscv_mdu_start(start),
      .i_riscv_mdu_mulctrl(mc),
      .i_riscv_mdu_divctrl(dc),
      .i_riscv_mdu_rs1data(rs1),
      .i_riscv_mdu_rs2data(rs2),
      .i_riscv_mdu_ack(ack),
      .i_riscv_mdu_kill(kill),
      .o_riscv_mdu_ready(ready),
      .o_riscv_mdu_busy(busy),
      .o_riscv_mdu_valid(valid),
      .o_riscv_mdu_result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] e);
      total++;
      assert (obs === e) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   task automatic issue(input logic [3:0] m, input logic [3:0] d, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      start = 1; mc = m; dc = d; rs1 = a; rs2 = b;
      @(posedge clk);
      #1;
      start = 0; mc = 0; dc = 0; rs1 = ~a; rs2 = ~b;
   endtask

   task automatic wait_valid(output int l);
      l = 0;
      while (valid !== 1'b1 && l < 200) begin
         @(posedge clk);
         #1;
         l++;
      end
   endtask

   task automatic do_ack();
      @(negedge clk);
      ack = 1;
      @(posedge clk);
      #1;
      ack = 0;
   endtask

   task automatic op(input string tag, input logic [3:0] m, input logic [3:0] d,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] e, input int elat);
      issue(m, d, a, b);
      wait_valid(lat);
      chk({tag, " latency"}, 64'(lat), 64'(elat));
      chk(tag, result, e);
      do_ack();
      chk({tag, " cleared"}, {63'b0, valid}, 64'd0);
   endtask

   initial begin
      #2 rst_n = 0;
      #1;
      chk("reset ready", {63'b0, ready}, 64'd1);
      chk("reset busy", {63'b0, busy}, 64'd0);
      chk("reset valid", {63'b0, valid}, 64'd0);
      chk("reset result", result, 64'd0);
      @(negedge clk);
      rst_n = 1;

      issue(4'b1000, 4'b0000, 64'd7, -64'sd3);
      chk("mul busy", {63'b0, busy}, 64'd1);
      wait_valid(lat);
      chk("mul latency", 64'(lat), 64'd33);
      chk("mul result", result, 64'hFFFF_FFFF_FFFF_FFEB);
      n = 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         n += int'(valid && result == 64'hFFFF_FFFF_FFFF_FFEB && !ready);
      end
      chk("mul hold", 64'(n), 64'd5);
      do_ack();
      chk("mul cleared", {63'b0, valid}, 64'd0);
      chk("mul idle ready", {63'b0, ready}, 64'd1);

      op("mulhu", 4'b1011, 4'b0000, '1, 64'd2, 64'd1, 33);
      op("mulhsu", 4'b1010, 4'b0000, '1, 64'd2, '1, 33);
      op("mulh", 4'b1001, 4'b0000, -64'sd2, 64'd3, '1, 33);
      op("mulw", 4'b1100, 4'b0000, 64'h1_0000_0003, 64'h7FFF_FFFF, 64'h7FFF_FFFD, 17);
      op("mul wins", 4'b1000, 4'b1010, 64'd6, 64'd7, 64'd42, 33);
      op("div", 4'b0000, 4'b1000, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66);
      op("rem", 4'b0000, 4'b1010, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66);
      op("divu", 4'b0000, 4'b1001, '1, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 66);
      op("divu by 0", 4'b0000, 4'b1001, 64'd5, 64'd0, '1, 2);
      op("remu by 0", 4'b0000, 4'b1011, 64'd5, 64'd0, 64'd5, 2);
      op("div ovf", 4'b0000, 4'b1000, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2);
      op("divw ovf", 4'b0000, 4'b1100, 64'h1_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 2);
      op("divw", 4'b0000, 4'b1100, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 34);
      op("remuw", 4'b0000, 4'b1111, 64'hDEAD_0000_0000_0011, 64'd5, 64'd2, 34);

      issue(4'b0000, 4'b1000, 64'd1000, 64'd7);
      repeat (9) @(posedge clk);
      @(negedge clk);
      kill = 1;
      @(posedge clk);
      #1;
      kill = 0;
      chk("kill busy", {63'b0, busy}, 64'd0);
      chk("kill ready", {63'b0, ready}, 64'd1);
      n = 0;
      repeat (80) begin
         @(posedge clk);
         #1;
         n += int'(valid);
      end
      chk("kill no valid", 64'(n), 64'd0);

      @(negedge clk);
      start = 1; kill = 1; mc = 4'b1000; rs1 = 64'd3; rs2 = 64'd3;
      @(posedge clk);
      #1;
      start = 0; kill = 0; mc = 0;
      chk("start+kill busy", {63'b0, busy}, 64'd0);
      n = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         n += int'(valid);
      end
      chk("start+kill no valid", 64'(n), 64'd0);

      issue(4'b1000, 4'b0000, 64'd3, 64'd5);
      wait_valid(lat);
      chk("b2b first", result, 64'd15);
      @(negedge clk);
      ack = 1; start = 1; mc = 4'b1000; rs1 = 64'd4; rs2 = 64'd6;
      @(posedge clk);
      #1;
      ack = 0; start = 0; mc = 0;
      chk("b2b valid drop", {63'b0, valid}, 64'd0);
      chk("b2b busy", {63'b0, busy}, 64'd1);
      wait_valid(lat);
      chk("b2b latency", 64'(lat), 64'd33);
      chk("b2b result", result, 64'd24);
      do_ack();

      issue(4'b0000, 4'b1000, -64'sd20, 64'd3);
      repeat (20) @(posedge clk);
      #3 rst_n = 0;
      #1;
      chk("async rst valid", {63'b0, valid}, 64'd0);
      chk("async rst ready", {63'b0, ready}, 64'd1);
      chk("async rst busy", {63'b0, busy}, 64'd0);
      chk("async rst result", result, 64'd0);
      @(negedge clk);
      rst_n = 1;
      n = 0;
      repeat (80) begin
         @(posedge clk);
         #1;
         n += int'(valid);
      end
      chk("async rst no valid", 64'(n), 64'd0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
